// File: rtl/alu_muldiv.sv
// alu_muldiv: EX-stage ALU with single-cycle logic/arith/shift/compare ops
// and iterative radix-2 signed/unsigned multiply and divide producing HI/LO.
module alu_muldiv #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             stallreq,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             whilo_o,
    output logic             ov_o,
    output logic             dbz_o
);

    localparam int unsigned SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_NOR   = 4'd5;
    localparam logic [3:0] OP_SLL   = 4'd6;
    localparam logic [3:0] OP_SRL   = 4'd7;
    localparam logic [3:0] OP_SRA   = 4'd8;
    localparam logic [3:0] OP_SLT   = 4'd9;
    localparam logic [3:0] OP_SLTU  = 4'd10;
    localparam logic [3:0] OP_MULT  = 4'd11;
    localparam logic [3:0] OP_MULTU = 4'd12;
    localparam logic [3:0] OP_DIV   = 4'd13;
    localparam logic [3:0] OP_DIVU  = 4'd14;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t             state;
    logic [SHW-1:0]     cnt;
    logic [WIDTH-1:0]   acc_hi;     // product high / partial remainder
    logic [WIDTH-1:0]   acc_lo;     // multiplier->product low / dividend->quotient
    logic [WIDTH-1:0]   opb;        // multiplicand / divisor magnitude
    logic               is_div_q;
    logic               sign_a_q;
    logic               sign_b_q;

    // Opcode decode for the incoming request
    logic md_op;
    logic div_op;
    logic signed_op;
    logic div_by_zero;

    always_comb begin
        md_op       = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
        div_op      = (op == OP_DIV) || (op == OP_DIVU);
        signed_op   = (op == OP_MULT) || (op == OP_DIV);
        div_by_zero = div_op && (b == '0);
    end

    // Pipeline hold: iterative op being accepted, or one already in flight
    assign stallreq = (state == BUSY) || (state == FIX) ||
                      ((state == IDLE) && start && !flush && md_op && !div_by_zero);

    // Single-cycle ALU datapath
    logic [WIDTH-1:0] alu_res;
    logic             alu_ov;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [SHW-1:0]   shamt;

    always_comb begin
        alu_res = '0;
        alu_ov  = 1'b0;
        sum     = a + b;
        diff    = a - b;
        shamt   = b[SHW-1:0];
        case (op)
            OP_ADD: begin
                alu_res = sum;
                alu_ov  = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ov  = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_NOR:  alu_res = ~(a | b);
            OP_SLL:  alu_res = a << shamt;
            OP_SRL:  alu_res = a >> shamt;
            OP_SRA:  alu_res = WIDTH'($signed(a) >>> shamt);
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
            default: alu_res = '0;
        endcase
    end

    // Operand magnitudes for signed iterative ops
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    always_comb begin
        mag_a = (signed_op && a[WIDTH-1]) ? (-a) : a;
        mag_b = (signed_op && b[WIDTH-1]) ? (-b) : b;
    end

    // One radix-2 step: shift-add multiply, restoring divide
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_trial;
    logic [WIDTH:0]   div_diff;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;

    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
        div_trial = {acc_hi, acc_lo[WIDTH-1]};
        div_diff  = div_trial - {1'b0, opb};
        if (is_div_q) begin
            if (!div_diff[WIDTH]) begin
                step_hi = div_diff[WIDTH-1:0];
                step_lo = {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                step_hi = div_trial[WIDTH-1:0];
                step_lo = {acc_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end
    end

    // Sign correction of the unsigned iteration result
    logic [2*WIDTH-1:0] prod_raw;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    always_comb begin
        prod_raw = {acc_hi, acc_lo};
        prod_fix = (sign_a_q ^ sign_b_q) ? (-prod_raw) : prod_raw;
        quo_fix  = (sign_a_q ^ sign_b_q) ? (-acc_lo) : acc_lo;
        rem_fix  = sign_a_q ? (-acc_hi) : acc_hi;
    end

    // Control FSM, iteration registers and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            opb      <= '0;
            is_div_q <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            done     <= 1'b0;
            whilo_o  <= 1'b0;
            ov_o     <= 1'b0;
            dbz_o    <= 1'b0;
            result   <= '0;
            hi_o     <= '0;
            lo_o     <= '0;
        end else begin
            done    <= 1'b0;
            whilo_o <= 1'b0;
            ov_o    <= 1'b0;
            dbz_o   <= 1'b0;
            if (flush) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            if (!md_op) begin
                                result <= alu_res;
                                ov_o   <= alu_ov;
                                done   <= 1'b1;
                            end else if (div_by_zero) begin
                                result  <= '1;
                                lo_o    <= '1;
                                hi_o    <= a;
                                dbz_o   <= 1'b1;
                                whilo_o <= 1'b1;
                                done    <= 1'b1;
                            end else begin
                                acc_hi   <= '0;
                                acc_lo   <= mag_a;
                                opb      <= mag_b;
                                is_div_q <= div_op;
                                sign_a_q <= signed_op && a[WIDTH-1];
                                sign_b_q <= signed_op && b[WIDTH-1];
                                cnt      <= '0;
                                state    <= BUSY;
                            end
                        end
                    end
                    BUSY: begin
                        acc_hi <= step_hi;
                        acc_lo <= step_lo;
                        if (cnt == SHW'(WIDTH - 1)) begin
                            state <= FIX;
                        end else begin
                            cnt <= cnt + SHW'(1);
                        end
                    end
                    FIX: begin
                        if (is_div_q) begin
                            lo_o   <= quo_fix;
                            hi_o   <= rem_fix;
                            result <= quo_fix;
                        end else begin
                            hi_o   <= prod_fix[2*WIDTH-1:WIDTH];
                            lo_o   <= prod_fix[WIDTH-1:0];
                            result <= prod_fix[WIDTH-1:0];
                        end
                        done    <= 1'b1;
                        whilo_o <= 1'b1;
                        cnt     <= '0;
                        state   <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed self-checking bench for alu_muldiv (WIDTH=32).
module tb_alu_muldiv;

    localparam int unsigned W = 32;

    logic         clk;
    logic         rst;
    logic         start;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         flush;
    logic         stallreq;
    logic         done;
    logic [W-1:0] result;
    logic [W-1:0] hi_o;
    logic [W-1:0] lo_o;
    logic         whilo_o;
    logic         ov_o;
    logic         dbz_o;

    int checks = 0;
    int errors = 0;

    alu_muldiv #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .flush    (flush),
        .stallreq (stallreq),
        .done     (done),
        .result   (result),
        .hi_o     (hi_o),
        .lo_o     (lo_o),
        .whilo_o  (whilo_o),
        .ov_o     (ov_o),
        .dbz_o    (dbz_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op at posedge+1 and wait (bounded) for done; counts edges and stall cycles
    task automatic run_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          output int edges, output int stalls);
        edges  = 0;
        stalls = 0;
        start  = 1'b1;
        op     = o;
        a      = x;
        b      = y;
        #1;
        if (stallreq) stalls++;
        tick();
        start = 1'b0;
        edges = 1;
        while (!done && edges < 60) begin
            if (stallreq) stalls++;
            tick();
            edges++;
        end
    endtask

    int edges;
    int stalls;
    int seen_done;

    initial begin
        rst   = 1'b0;
        start = 1'b0;
        op    = 4'd0;
        a     = '0;
        b     = '0;
        flush = 1'b0;
        #12;
        check("rst_done",     64'(done),     64'd0);
        check("rst_stallreq", 64'(stallreq), 64'd0);
        check("rst_result",   64'(result),   64'd0);
        check("rst_hi",       64'(hi_o),     64'd0);
        check("rst_lo",       64'(lo_o),     64'd0);
        check("rst_flags",    64'({whilo_o, ov_o, dbz_o}), 64'd0);
        rst = 1'b1;
        tick();

        // ADD overflow
        run_op(4'd0, 32'h7FFF_FFFF, 32'h0000_0001, edges, stalls);
        check("add_edges",  64'(edges),   64'd1);
        check("add_stalls", 64'(stalls),  64'd0);
        check("add_result", 64'(result),  64'h8000_0000);
        check("add_ov",     64'(ov_o),    64'd1);
        check("add_whilo",  64'(whilo_o), 64'd0);
        tick();
        check("add_pulse",  64'({done, ov_o}), 64'd0);
        check("add_hold",   64'(result),  64'h8000_0000);

        // SUB overflow, SLT signed, NOR, SLL
        run_op(4'd1, 32'h8000_0000, 32'h0000_0001, edges, stalls);
        check("sub_result", 64'(result), 64'h7FFF_FFFF);
        check("sub_ov",     64'(ov_o),   64'd1);
        run_op(4'd9, 32'hFFFF_FFFF, 32'h0000_0001, edges, stalls);
        check("slt_result", 64'(result), 64'd1);
        run_op(4'd5, 32'h0F0F_0000, 32'h0000_00F0, edges, stalls);
        check("nor_result", 64'(result), 64'hF0F0_FF0F);
        run_op(4'd6, 32'h0000_0003, 32'h0000_0024, edges, stalls);
        check("sll_result", 64'(result), 64'h0000_0030);

        // SRA then SLTU back-to-back
        run_op(4'd8, 32'h8000_0000, 32'h0000_0004, edges, stalls);
        check("sra_result", 64'(result), 64'hF800_0000);
        check("sra_done",   64'(done),   64'd1);
        run_op(4'd10, 32'h0000_0001, 32'hFFFF_FFFF, edges, stalls);
        check("sltu_result", 64'(result), 64'd1);
        check("sltu_done",   64'(done),   64'd1);
        tick();
        check("sltu_pulse",  64'(done),   64'd0);

        // MULT -2 * 3
        run_op(4'd11, 32'hFFFF_FFFE, 32'h0000_0003, edges, stalls);
        check("mult_edges",  64'(edges),    64'd34);
        check("mult_stalls", 64'(stalls),   64'd34);
        check("mult_hi",     64'(hi_o),     64'hFFFF_FFFF);
        check("mult_lo",     64'(lo_o),     64'hFFFF_FFFA);
        check("mult_result", 64'(result),   64'hFFFF_FFFA);
        check("mult_whilo",  64'(whilo_o),  64'd1);
        check("mult_stall_done", 64'(stallreq), 64'd0);
        tick();
        check("mult_pulse",  64'({done, whilo_o}), 64'd0);

        // MULTU max * max
        run_op(4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, edges, stalls);
        check("multu_hi", 64'(hi_o), 64'hFFFF_FFFE);
        check("multu_lo", 64'(lo_o), 64'h0000_0001);

        // DIV -7 / 2
        run_op(4'd13, 32'hFFFF_FFF9, 32'h0000_0002, edges, stalls);
        check("div_edges",  64'(edges),  64'd34);
        check("div_lo",     64'(lo_o),   64'hFFFF_FFFD);
        check("div_hi",     64'(hi_o),   64'hFFFF_FFFF);
        check("div_result", 64'(result), 64'hFFFF_FFFD);
        check("div_dbz",    64'(dbz_o),  64'd0);

        // DIV -2^31 / -1
        run_op(4'd13, 32'h8000_0000, 32'hFFFF_FFFF, edges, stalls);
        check("divovf_lo",  64'(lo_o),  64'h8000_0000);
        check("divovf_hi",  64'(hi_o),  64'd0);
        check("divovf_dbz", 64'(dbz_o), 64'd0);

        // DIVU by zero
        run_op(4'd14, 32'h0000_0007, 32'h0000_0000, edges, stalls);
        check("dbz_edges",  64'(edges),   64'd1);
        check("dbz_stalls", 64'(stalls),  64'd0);
        check("dbz_flag",   64'(dbz_o),   64'd1);
        check("dbz_whilo",  64'(whilo_o), 64'd1);
        check("dbz_lo",     64'(lo_o),    64'hFFFF_FFFF);
        check("dbz_hi",     64'(hi_o),    64'h0000_0007);
        check("dbz_result", 64'(result),  64'hFFFF_FFFF);
        tick();
        check("dbz_pulse",  64'({done, dbz_o, whilo_o}), 64'd0);

        // MULTU flushed at iteration 10
        start = 1'b1;
        op    = 4'd12;
        a     = 32'd5;
        b     = 32'd6;
        tick();
        start = 1'b0;
        seen_done = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done || whilo_o) seen_done++;
        end
        flush = 1'b1;
        #1;
        check("flush_stall_before", 64'(stallreq), 64'd1);
        tick();
        flush = 1'b0;
        check("flush_stall_after", 64'(stallreq), 64'd0);
        for (int i = 0; i < 40; i++) begin
            if (done || whilo_o) seen_done++;
            tick();
        end
        check("flush_no_done", 64'(seen_done), 64'd0);
        check("flush_hi_kept", 64'(hi_o), 64'h0000_0007);
        check("flush_lo_kept", 64'(lo_o), 64'hFFFF_FFFF);
        run_op(4'd0, 32'd2, 32'd3, edges, stalls);
        check("post_flush_edges", 64'(edges),  64'd1);
        check("post_flush_add",   64'(result), 64'd5);
        tick();

        // start together with flush is dropped
        start = 1'b1;
        flush = 1'b1;
        op    = 4'd0;
        a     = 32'd10;
        b     = 32'd10;
        tick();
        start = 1'b0;
        flush = 1'b0;
        check("flush_start_done",   64'(done),   64'd0);
        check("flush_start_result", 64'(result), 64'd5);

        // DIVU in flight: start ignored, then async reset mid-cycle
        start = 1'b1;
        op    = 4'd14;
        a     = 32'd100;
        b     = 32'd7;
        tick();
        start = 1'b0;
        tick();
        tick();
        start = 1'b1;
        op    = 4'd0;
        a     = 32'd2;
        b     = 32'd2;
        #1;
        check("busy_stall", 64'(stallreq), 64'd1);
        tick();
        start = 1'b0;
        check("busy_ignore_done",   64'(done),     64'd0);
        check("busy_ignore_result", 64'(result),   64'd5);
        check("busy_still_stall",   64'(stallreq), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        check("arst_stall",  64'(stallreq), 64'd0);
        check("arst_result", 64'(result),   64'd0);
        check("arst_hilo",   64'({hi_o, lo_o}), 64'd0);
        check("arst_flags",  64'({done, whilo_o, ov_o, dbz_o}), 64'd0);
        tick();
        check("arst_held_done", 64'(done), 64'd0);
        rst = 1'b1;
        tick();
        check("arst_idle_stall", 64'(stallreq), 64'd0);

        // Fresh DIVU after reset: 100 / 7
        run_op(4'd14, 32'd100, 32'd7, edges, stalls);
        check("divu_edges", 64'(edges), 64'd34);
        check("divu_lo",    64'(lo_o),  64'd14);
        check("divu_hi",    64'(hi_o),  64'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
- Parametrised successor to the single-cycle execute ALU.
- Performs single-cycle logic, arithmetic, shift and compare ops, plus iterative multi-cycle signed/unsigned multiply and divide with a HI/LO result pair.
- Sits in the EX stage. Raises stallreq to freeze the pipeline while an iterative op runs, and reports signed-add overflow and divide-by-zero to downstream logic.

Parameters:
- WIDTH, 32, operand/result width; power of two, minimum 8.
- SHW, log2(WIDTH), shift-amount width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-low reset (rst==0 resets)
- start  in  1  operation valid this cycle
- op  in  4  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLL, 7 SRL, 8 SRA, 9 SLT, 10 SLTU, 11 MULT, 12 MULTU, 13 DIV, 14 DIVU, 15 reserved
- a  in  WIDTH  operand 1
- b  in  WIDTH  operand 2
- flush  in  1  abort current/pending op
- stallreq  out  1  pipeline hold request
- done  out  1  one-cycle result-valid pulse
- result  out  WIDTH  primary result
- hi_o  out  WIDTH  HI value (product high / remainder)
- lo_o  out  WIDTH  LO value (product low / quotient)
- whilo_o  out  1  HI/LO write enable, valid with done
- ov_o  out  1  signed overflow (ADD/SUB), valid with done
- dbz_o  out  1  divide by zero, valid with done

Behaviour:
- Reset (async, rst low): state IDLE, counter 0. done, whilo_o, ov_o, dbz_o and stallreq are 0. result, hi_o and lo_o are 0.
- States: IDLE, BUSY, FIX.
- All outputs except stallreq are registered.
- done, whilo_o, ov_o and dbz_o are pulses. They are 0 in any cycle where done is 0.
- result, hi_o and lo_o hold their last value until the next done.
- Single-cycle ops (0–10, 15), IDLE with start=1:
  - Outputs load at the next edge with done=1 and whilo_o=0.
  - ADD/SUB: result = a±b mod 2^WIDTH. ov_o = signed overflow. The result is still driven; the consumer suppresses writeback.
  - AND, OR, XOR, NOR: bitwise.
  - SLL/SRL/SRA: a shifted by b[SHW-1:0]; SRA sign-fills.
  - SLT/SLTU: result = 1 if a<b (signed/unsigned), else 0.
  - op 15: result 0, done=1.
- Multi-cycle ops (11–14), IDLE with start=1:
  - Latch the operands. Signed ops convert to magnitudes and record the sign(s).
  - Go to BUSY, counter=0.
- BUSY: one radix-2 iteration per cycle, WIDTH iterations total.
  - Multiply: shift-add.
  - Divide: restoring.
  - When the counter reaches WIDTH-1, go to FIX.
- FIX: apply sign correction on the clock edge leaving FIX, then go to IDLE with done=1 and whilo_o=1.
  - MULT: product negated if sign(a)^sign(b).
  - DIV: quotient negated if sign(a)^sign(b); remainder takes the sign of a.
- Latency: done rises WIDTH+2 edges after the start edge. Single-cycle ops: 1 edge.
- Multiply outputs: {hi_o, lo_o} = 2·WIDTH-bit product; result = lo_o.
- Divide outputs: lo_o = quotient, hi_o = remainder, result = quotient.
- Divide by zero (b==0, op 13/14):
  - No iteration; done after 1 edge.
  - dbz_o=1, whilo_o=1, lo_o = all ones, hi_o = a, result = all ones.
- Signed DIV of -2^(WIDTH-1) by -1: quotient -2^(WIDTH-1), remainder 0, no flag.
- stallreq (combinational):
  - 1 when (IDLE & start & op∈{11..14} & b≠0 for div), or state∈{BUSY, FIX}.
  - 0 in the cycle done is high.
  - Never asserted for single-cycle ops or divide-by-zero.
- start while BUSY or FIX: ignored; operands are not re-latched.
- flush: highest priority over start.
  - Next edge goes to IDLE with no done and no whilo_o.
  - result/hi_o/lo_o are unchanged.
  - A start in the same cycle as flush is dropped.
- Async reset mid-operation: immediate return to IDLE with reset values; no done.

Test Plan:
- ADD a=0x7FFFFFFF, b=1 -> 1 edge later done=1, result=0x80000000, ov_o=1, whilo_o=0, stallreq never high.
- SRA a=0x80000000, b=4; then SLTU a=1, b=0xFFFFFFFF -> result 0xF8000000, then result 1; one done per op.
- MULT a=0xFFFFFFFE (-2), b=3 -> stallreq high from the start cycle for 34 cycles, done at edge 34 (WIDTH+2), hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFA, whilo_o=1.
- DIV a=-7 (0xFFFFFFF9), b=2 -> lo_o=0xFFFFFFFD (-3), hi_o=0xFFFFFFFF (-1); DIVU a=7, b=0 -> done after 1 edge, dbz_o=1, lo_o=0xFFFFFFFF, hi_o=7, stallreq 0.
- MULTU start, flush asserted at iteration 10 -> no done/whilo_o pulse, stallreq drops after the flush edge, prior hi_o/lo_o retained; a following ADD 2+3 gives result 5 one edge later.
- DIVU in flight, rst driven low asynchronously mid-cycle -> all outputs 0 immediately, state IDLE; start with new op still ignored while BUSY (checked before reset).
